stream_decrypt: RTL and testbench
=================================

STREAM_DECRYPT -- requirements
Module: stream_decrypt

Interface
REQ-001 Parameter: SEED, default 8'b1110_1110, keystream and key value applied at reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: load_seed  input  1  one-cycle request to load a new key.
REQ-005 Port: seed_in  input  8  key value captured when load_seed=1.
REQ-006 Port: ct_valid  input  1  ciphertext byte available.
REQ-007 Port: ct_data  input  8  ciphertext byte.
REQ-008 Port: ct_ready  output  1  block accepts ciphertext this cycle.
REQ-009 Port: pt_valid  output  1  plaintext byte held in the output register.
REQ-010 Port: pt_data  output  8  plaintext byte.
REQ-011 Port: pt_ready  input  1  downstream accepts plaintext this cycle.
REQ-012 Port: byte_count  output  16  bytes decrypted since the last reset or key load.

Function
REQ-013 The block SHALL hold an 8-bit key register (key) and an 8-bit keystream register (ks).
REQ-014 Feedback bit fb SHALL equal key[7]^key[6]^key[3]^key[2]. fb is constant between key loads, which makes the keystream match the transmit side.
REQ-015 Keystream advance SHALL be ks <= {fb, ks[7:1]}.
REQ-016 ct_ready SHALL equal !load_seed && (!pt_valid || pt_ready); it is combinational.
REQ-017 Accept is ct_valid && ct_ready. On accept the block SHALL set pt_data <= ct_data ^ ks (the pre-advance ks), set pt_valid <= 1, advance ks once, and increment byte_count.
REQ-018 Latency SHALL be one cycle from ciphertext accept to pt_valid. Throughput is one byte per cycle while pt_ready=1.
REQ-019 Output drain: if pt_valid && pt_ready and no accept occurs in the same cycle, pt_valid SHALL go to 0.
REQ-020 Accept and drain in the same cycle SHALL keep pt_valid=1 with the new byte; no byte is lost or duplicated.
REQ-021 While pt_valid=1 and pt_ready=0, pt_data, ks and byte_count SHALL hold.
REQ-022 load_seed=1 SHALL set key <= seed_in, ks <= seed_in and byte_count <= 0. No ciphertext is accepted in that cycle.
REQ-023 load_seed SHALL leave pt_valid and pt_data unchanged. A pending plaintext byte still drains normally.
REQ-024 load_seed takes priority over ct_valid in the same cycle; the ciphertext byte stays pending upstream.
REQ-025 byte_count SHALL wrap from 16'hFFFF to 16'h0000 with no other effect.
REQ-026 ks SHALL advance only on accept; idle cycles and stall cycles leave it unchanged.
REQ-027 The block SHALL have two implicit states:
- EMPTY (pt_valid=0): EMPTY -> FULL on accept.
- FULL (pt_valid=1): FULL -> EMPTY on drain without accept.
- All other cases stay in the current state.

Reset
REQ-028 While rst=1 and immediately on its assertion, the block SHALL force:
- key = SEED, ks = SEED;
- pt_valid = 0, pt_data = 8'h00;
- byte_count = 16'h0000.
REQ-029 Reset asserted mid-stream SHALL discard any pending plaintext byte. No accept occurs while rst=1.
REQ-030 After rst deasserts, ct_ready SHALL be 1 in the first cycle, provided load_seed=0.

Verification
REQ-031 Reset, then ct_data=00 for three consecutive accepts with pt_ready=1 -> pt_data 8'hEE, 8'h77, 8'h3B; byte_count=3.
REQ-032 load_seed with seed_in=8'h80, then four accepts of 00 -> pt_data 80, C0, E0, F0; byte_count=4.
REQ-033 Stall: pt_ready=0 with pt_valid=1 -> ct_ready=0; pt_data, ks and byte_count hold. Then pt_ready=1 -> one drain and the next byte is accepted the same cycle.
REQ-034 load_seed=1 and ct_valid=1 in the same cycle -> ct_ready=0 and no accept. The next accept uses ks=seed_in, and byte_count becomes 1.
REQ-035 Round trip: a 256-byte random plaintext XORed with the reference keystream for seed 8'hA5, fed through the block -> original plaintext exactly, with random pt_ready backpressure applied.
REQ-036 rst pulsed while pt_valid=1 -> pt_valid=0 asynchronously. The first byte after release decrypts with ks=8'hEE.

Source files
------------

// File: rtl/stream_decrypt.sv
// Byte-serial stream decryptor: XORs ciphertext with an 8-bit keystream.
// One-entry output register with valid/ready handshake on both sides.
module stream_decrypt #(
  parameter logic [7:0] SEED = 8'b1110_1110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_seed,
  input  logic [7:0]  seed_in,
  input  logic        ct_valid,
  input  logic [7:0]  ct_data,
  output logic        ct_ready,
  output logic        pt_valid,
  output logic [7:0]  pt_data,
  input  logic        pt_ready,
  output logic [15:0] byte_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  ks_q, ks_d;
  logic [7:0]  pt_data_q, pt_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fb, accept, drain;

  // Feedback depends only on the key, so it is fixed between key loads.
  assign fb = key_q[7] ^ key_q[6] ^ key_q[3] ^ key_q[2];

  assign pt_valid   = (state_q == FULL);
  assign pt_data    = pt_data_q;
  assign byte_count = cnt_q;
  assign ct_ready   = !load_seed && (!pt_valid || pt_ready);
  assign accept     = ct_valid && ct_ready;
  assign drain      = pt_valid && pt_ready;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ks_d      = ks_q;
    pt_data_d = pt_data_q;
    cnt_d     = cnt_q;
    if (load_seed) begin
      key_d = seed_in;
      ks_d  = seed_in;
      cnt_d = 16'h0000;
    end else if (accept) begin
      pt_data_d = ct_data ^ ks_q;
      ks_d      = {fb, ks_q[7:1]};
      cnt_d     = cnt_q + 16'h0001;
    end
    if (accept)
      state_d = FULL;
    else if (drain)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      key_q     <= SEED;
      ks_q      <= SEED;
      pt_data_q <= 8'h00;
      cnt_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      ks_q      <= ks_d;
      pt_data_q <= pt_data_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_decrypt.sv
// Scoreboard bench for stream_decrypt: driver models the handshake and
// keystream, monitor pops expected plaintext whenever a byte drains.
module tb_stream_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_seed;
  logic [7:0]  seed_in;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic [15:0] byte_count;

  stream_decrypt dut (
    .clk(clk), .rst(rst), .load_seed(load_seed), .seed_in(seed_in),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  int m_key, m_ks, m_cnt;
  bit m_pv;
  bit last_acc;
  bit rt_mode = 1'b0;
  byte unsigned exp_q[$];
  byte unsigned rt_pt[$];

  function automatic int next_ks(input int key, input int ks);
    int fb;
    fb = ((key >> 7) & 1) ^ ((key >> 6) & 1) ^ ((key >> 3) & 1) ^ ((key >> 2) & 1);
    return (fb << 7) | (ks >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_key = 8'hEE; m_ks = 8'hEE; m_cnt = 0; m_pv = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle (called at posedge+1), check/advance model at negedge.
  task automatic cyc(input bit ld, input byte unsigned sd, input bit cv,
                     input byte unsigned cd, input bit pr);
    bit rdy;
    load_seed = ld; seed_in = sd; ct_valid = cv; ct_data = cd; pt_ready = pr;
    @(negedge clk);
    rdy = !ld && (!m_pv || pr);
    check("ct_ready", ct_ready, rdy);
    check("pt_valid", pt_valid, m_pv);
    check("byte_count", byte_count, m_cnt);
    last_acc = cv && rdy;
    if (ld) begin
      m_key = sd; m_ks = sd; m_cnt = 0;
      if (m_pv && pr) m_pv = 1'b0;
    end else if (last_acc) begin
      if (rt_mode) exp_q.push_back(rt_pt.pop_front());
      else exp_q.push_back(byte'(cd ^ m_ks[7:0]));
      m_ks  = next_ks(m_key, m_ks);
      m_cnt = (m_cnt + 1) & 16'hFFFF;
      m_pv  = 1'b1;
    end else if (m_pv && pr) begin
      m_pv = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // monitor: a byte leaves the block on every pt_valid && pt_ready edge
  always @(negedge clk) begin
    if (!rst && pt_valid && pt_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pt_unexpected: got %0h with empty scoreboard at %0t", pt_data, $time);
      end else begin
        check("pt_data", pt_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    byte unsigned ct_arr[256];
    int ks, idx, guard;
    rst = 1'b1; load_seed = 0; seed_in = 0; ct_valid = 0; ct_data = 0; pt_ready = 0;
    model_reset();
    @(negedge clk);
    check("rst_pt_valid", pt_valid, 0);
    check("rst_pt_data", pt_data, 0);
    check("rst_byte_count", byte_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // default seed keystream: EE 77 3B
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h00, 1);
    cyc(0, 0, 0, 0, 1);
    check("count_after_3", byte_count, 3);

    // new key 80: 80 C0 E0 F0
    cyc(1, 8'h80, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h00, 1);
    cyc(0, 0, 0, 0, 1);
    check("count_after_4", byte_count, 4);

    // stall then release with simultaneous accept
    cyc(0, 0, 1, 8'h3C, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h55, 0);
    check("stall_count", byte_count, 5);
    cyc(0, 0, 1, 8'h55, 1);
    cyc(0, 0, 0, 0, 1);

    // load_seed beats ct_valid; next accept uses ks = seed
    cyc(1, 8'h5A, 1, 8'hAA, 1);
    cyc(0, 0, 1, 8'hAA, 1);
    cyc(0, 0, 0, 0, 1);
    check("seed_prio_count", byte_count, 1);

    // round trip with seed A5 under random backpressure
    cyc(1, 8'hA5, 0, 0, 1);
    ks = 8'hA5;
    for (int i = 0; i < 256; i++) begin
      byte unsigned p;
      p = byte'($urandom);
      rt_pt.push_back(p);
      ct_arr[i] = p ^ ks[7:0];
      ks = next_ks(8'hA5, ks);
    end
    rt_mode = 1'b1;
    idx = 0; guard = 0;
    while (idx < 256 && guard < 5000) begin
      cyc(0, 0, ($urandom_range(0, 3) != 0), ct_arr[idx], $urandom_range(0, 1));
      if (last_acc) idx++;
      guard++;
    end
    check("rt_fed_all", idx, 256);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    rt_mode = 1'b0;
    check("rt_count", byte_count, 256);

    // async reset while a byte is pending
    cyc(0, 0, 1, 8'h12, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pt_valid", pt_valid, 0);
    check("async_rst_pt_data", pt_data, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 1, 8'h00, 1);
    cyc(0, 0, 0, 0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
